if_fetch: RTL and testbench

- Instruction-fetch front end of the MIPS pipeline.
- Owns the PC and drives a valid/ready request port into instruction ROM. Accepts the ROM's data response.
- Buffers fetched {pc, inst} pairs in a 2-entry FIFO and presents the head to the IF/ID pipeline register as if_pc/if_inst.
- Handles downstream stall and branch redirect, including the MIPS delay slot.

---
 rtl/if_fetch_pkg.sv | 31 +++
 rtl/if_fetch_fifo.sv | 84 ++++++++
 rtl/if_fetch.sv | 160 ++++++++++++++++
 tb/tb_if_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t ZERO_WORD    = 32'h0000_0000;
    localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10
    } fetch_state_e;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = {ZERO_WORD, ZERO_WORD};

    // Sequential fetch address; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic inst_addr_t next_pc(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Two-entry {pc, inst} buffer between the ROM response and IF/ID.
// Flush wins over push and pop; a push on a full buffer is taken only alongside a pop.
module if_fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         do_push_s, do_pop_s;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign head  = empty ? ENTRY_ZERO : mem_q[rd_ptr_q];

    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Next pointer, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENTRY_ZERO;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, keeps at most one ROM request in flight
// and presents buffered {pc, inst} pairs to IF/ID, honouring stall and delayed branches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC  = RESET_PC_DEF,
    parameter int         BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce,
    output logic        rom_req_valid,
    output logic [31:0] rom_req_addr,
    input  logic        rom_req_ready,
    input  logic        rom_resp_valid,
    input  logic [31:0] rom_resp_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    inst_addr_t   pc_q, pc_d;
    inst_addr_t   req_pc_q, req_pc_d;
    logic         outstanding_q, outstanding_d;
    logic         drop_q, drop_d;
    logic         pend_redir_q, pend_redir_d;
    inst_addr_t   pend_target_q, pend_target_d;

    logic         fifo_empty_s, fifo_full_s;
    logic [1:0]   fifo_count_s;
    fetch_entry_t fifo_head_s;
    fetch_entry_t push_entry_s;
    logic [2:0]   occ_sum_s;
    logic         req_fire_s, resp_fire_s, pop_s, push_s, redir_s;
    inst_addr_t   redir_tgt_s;

    if_fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_entry(push_entry_s),
        .pop       (pop_s),
        .flush     (redir_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Requests are gated so that every response in flight is guaranteed a free slot.
    assign occ_sum_s     = {1'b0, fifo_count_s} + {2'b00, outstanding_q};
    assign rom_ce        = (state_q != FETCH_IDLE);
    assign rom_req_valid = (state_q == FETCH_REQ) && !fifo_full_s && (occ_sum_s < 3'd2);
    assign rom_req_addr  = pc_q;

    assign req_fire_s   = rom_req_valid && rom_req_ready;
    assign resp_fire_s  = (state_q == FETCH_WAIT) && outstanding_q && rom_resp_valid;
    assign push_s       = resp_fire_s && !drop_q;
    assign push_entry_s = {req_pc_q, rom_resp_data};

    // The popped entry is the delay slot; everything younger is flushed with it.
    assign pop_s       = !stall_i && !fifo_empty_s;
    assign redir_s     = pop_s && (branch_flag_i || pend_redir_q);
    assign redir_tgt_s = branch_flag_i ? branch_target_i : pend_target_q;

    assign if_valid = !fifo_empty_s;
    assign if_pc    = fifo_head_s.pc;
    assign if_inst  = fifo_head_s.inst;

    // Next-state logic for the fetch FSM, PC and redirect bookkeeping.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        pend_redir_d  = pend_redir_q;
        pend_target_d = pend_target_q;

        case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (req_fire_s) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (resp_fire_s) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (req_fire_s) begin
            outstanding_d = 1'b1;
            req_pc_d      = pc_q;
        end else if (resp_fire_s) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end

        // A request accepted in the redirect cycle still carries the old PC.
        if (redir_s) begin
            pc_d          = redir_tgt_s;
            drop_d        = req_fire_s || (outstanding_q && !resp_fire_s);
            pend_redir_d  = 1'b0;
        end else begin
            if (req_fire_s) begin
                pc_d = next_pc(pc_q);
            end else begin
                pc_d = pc_q;
            end
            if (resp_fire_s) begin
                drop_d = 1'b0;
            end else begin
                drop_d = drop_q;
            end
            if (branch_flag_i) begin
                pend_redir_d  = 1'b1;
                pend_target_d = branch_target_i;
            end else begin
                pend_redir_d  = pend_redir_q;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            pend_redir_q  <= 1'b0;
            pend_target_q <= ZERO_WORD;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            pend_redir_q  <= pend_redir_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a behavioural ROM plus a program-order model of
// the fetched stream (sequential PCs, delayed branches) judge every request and pop.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce;
    logic        rom_req_valid;
    logic [31:0] rom_req_addr;
    logic        rom_req_ready;
    logic        rom_resp_valid;
    logic [31:0] rom_resp_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int          n_cmp;
    int          n_err;

    bit          rom_busy;
    int          rom_cnt;
    logic [31:0] rom_addr;
    int          lat_fix;

    logic [31:0] exp_pc;
    logic [31:0] next_req;
    logic [31:0] pend_tgt;
    bit          pend_flag;
    int          rst_age;
    int          since_rel;
    bit          first_req;
    int          idle_cnt;

    bit          smp_req_valid;
    bit          smp_if_valid;
    logic [31:0] smp_if_pc;
    logic [31:0] smp_if_inst;
    bit          smp_pop;

    int          st_cnt;
    bit          br_done;
    bit          done;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_ce         (rom_ce),
        .rom_req_valid  (rom_req_valid),
        .rom_req_addr   (rom_req_addr),
        .rom_req_ready  (rom_req_ready),
        .rom_resp_valid (rom_resp_valid),
        .rom_resp_data  (rom_resp_data),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ ~a[17:2]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive ROM response, sample at negedge against the model, return at posedge+1.
    task automatic step();
        if (rst) begin
            rom_resp_valid = 1'b0;
            rom_resp_data  = $urandom();
            if (rom_busy) rom_cnt = 1;
        end else if (rom_busy && rom_cnt <= 1) begin
            rom_resp_valid = 1'b1;
            rom_resp_data  = rom_word(rom_addr);
            rom_busy       = 1'b0;
        end else begin
            rom_resp_valid = 1'b0;
            rom_resp_data  = $urandom();
            if (rom_busy) rom_cnt--;
        end

        @(negedge clk);
        smp_req_valid = rom_req_valid;
        smp_if_valid  = if_valid;
        smp_if_pc     = if_pc;
        smp_if_inst   = if_inst;
        smp_pop       = 1'b0;

        if (rst) begin
            if (rst_age > 0) begin
                check_val("rst_ce", {31'd0, rom_ce}, 32'd0);
                check_val("rst_req_valid", {31'd0, rom_req_valid}, 32'd0);
                check_val("rst_req_addr", rom_req_addr, RESET_PC);
                check_val("rst_if_valid", {31'd0, if_valid}, 32'd0);
                check_val("rst_if_pc", if_pc, 32'd0);
                check_val("rst_if_inst", if_inst, 32'd0);
            end
            rst_age++;
            since_rel = 0;
            exp_pc    = RESET_PC;
            next_req  = RESET_PC;
            pend_flag = 1'b0;
            first_req = 1'b1;
            idle_cnt  = 0;
        end else begin
            rst_age = 0;
            if (since_rel == 0) check_val("ce_low_after_rst", {31'd0, rom_ce}, 32'd0);
            if (since_rel == 1) check_val("ce_high", {31'd0, rom_ce}, 32'd1);
            if (!if_valid) begin
                check_val("empty_pc", if_pc, 32'd0);
                check_val("empty_inst", if_inst, 32'd0);
            end
            if (rom_req_valid) begin
                check_val("req_ce", {31'd0, rom_ce}, 32'd1);
                check_val("one_outstanding", {31'd0, rom_busy}, 32'd0);
                check_val("req_addr", rom_req_addr, next_req);
                if (first_req) begin
                    check_val("first_addr", rom_req_addr, RESET_PC);
                    first_req = 1'b0;
                end
                if (rom_req_ready) begin
                    rom_busy = 1'b1;
                    rom_addr = rom_req_addr;
                    rom_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1));
                    next_req = next_req + 32'd4;
                end
            end
            if (branch_flag_i) begin
                pend_flag = 1'b1;
                pend_tgt  = branch_target_i;
            end
            if (if_valid && !stall_i) begin
                smp_pop = 1'b1;
                check_val("pop_pc", if_pc, exp_pc);
                check_val("pop_inst", if_inst, rom_word(exp_pc));
                if (pend_flag) begin
                    exp_pc   = pend_tgt;
                    next_req = pend_tgt;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
                pend_flag = 1'b0;
                idle_cnt  = 0;
            end else if (!stall_i) begin
                idle_cnt++;
                if (idle_cnt > 40) begin
                    check_val("progress", 32'(idle_cnt), 32'd0);
                    idle_cnt = 0;
                end
            end
            since_rel++;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'd0;
        rom_req_ready = 1'b0; rom_resp_valid = 1'b0; rom_resp_data = 32'd0;
        rom_busy = 1'b0; rom_cnt = 0; rom_addr = 32'd0; lat_fix = 1;
        exp_pc = RESET_PC; next_req = RESET_PC; pend_tgt = 32'd0; pend_flag = 1'b0;
        rst_age = 0; since_rel = 0; first_req = 1'b1; idle_cnt = 0;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Sequential fetch, 5-cycle stall on the first entry, then branch to 0x100 while 8 pops.
        rom_req_ready = 1'b1;
        st_cnt = 0; br_done = 1'b0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            stall_i = 1'b0;
            branch_flag_i = 1'b0;
            if (if_valid && st_cnt < 5) begin
                stall_i = 1'b1;
                st_cnt++;
            end
            if (!br_done && st_cnt == 5 && !stall_i && if_valid && if_pc == 32'h8) begin
                branch_flag_i   = 1'b1;
                branch_target_i = 32'h100;
                br_done         = 1'b1;
            end
            step();
            if (stall_i && st_cnt == 5) begin
                check_val("stall_gate", {31'd0, smp_req_valid}, 32'd0);
                check_val("stall_head", smp_if_pc, 32'd0);
            end
            if (smp_pop && smp_if_pc == 32'h104) done = 1'b1;
        end
        check_val("br_target_reached", {31'd0, done}, 32'd1);
        branch_flag_i = 1'b0;
        stall_i = 1'b0;

        // ROM not ready for 4 cycles: request held, buffer drains.
        rom_req_ready = 1'b0;
        for (int i = 0; i < 20 && !rom_req_valid; i++) step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("hold_valid", {31'd0, smp_req_valid}, 32'd1);
        end
        check_val("drained_valid", {31'd0, smp_if_valid}, 32'd0);
        check_val("drained_inst", smp_if_inst, 32'd0);
        rom_req_ready = 1'b1;

        // Slow ROM, branch while the buffer is empty: next pop is the delay slot.
        lat_fix = 3;
        for (int i = 0; i < 20 && if_valid; i++) step();
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h200;
        step();
        branch_flag_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            step();
            if (smp_pop && smp_if_pc == 32'h200) done = 1'b1;
        end
        check_val("br_empty_reached", {31'd0, done}, 32'd1);

        // Reset while a request is in flight; its response lands just after release.
        for (int i = 0; i < 20 && !rom_busy; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        lat_fix = 1;
        for (int i = 0; i < 30; i++) step();

        // Randomised traffic: stalls, back-pressure, latency, branches, wrap targets, resets.
        lat_fix = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rst && $urandom_range(999) == 0) begin
                rst = 1'b1;
            end else if (rst && rst_age >= 2) begin
                rst = 1'b0;
            end
            stall_i         = ($urandom_range(99) < 30);
            rom_req_ready   = ($urandom_range(99) < 70);
            branch_flag_i   = !rst && ($urandom_range(99) < 6);
            branch_target_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            step();
        end
        branch_flag_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
